// File: rtl/trdb_resync_arbiter.sv
// trdb_resync_arbiter
// Takes the resync counter's resync_max level and waits for a slot with no
// packet in progress (or gives up waiting after MAX_WAIT cycles). It then
// requests a sync packet from the emitter, pulses resync_rst_o back to the
// counter once the request is acked, and keeps a saturating count of
// completed resyncs.
//
// Optional feature macro: TRDB_FORCE_RESYNC_EN
//   When defined, this adds the force_resync_i port. A software pulse on it
//   starts a resync from IDLE.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no resync in flight; watching for a trigger
// WAIT_SLOT | resync wanted; waiting for the emitter to be free
// REQ       | sync_req_o asserted; waiting for sync_ack_i
// CLEAR     | one-cycle resync_rst_o pulse to the counter, count bumped
module trdb_resync_arbiter #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
`ifdef TRDB_FORCE_RESYNC_EN
    input  logic             force_resync_i,
`endif
    input  logic             trace_enabled_i,
    input  logic             resync_max_i,
    input  logic             packet_busy_i,
    input  logic             sync_ack_i,
    output logic             sync_req_o,
    output logic             resync_rst_o,
    output logic             resync_pending_o,
    output logic [CNT_W-1:0] resync_count_o
);

    localparam int                WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SLOT,
        ST_REQ,
        ST_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               blank_q, blank_d;
    logic               force_trig;
    logic               trigger;

    // Software force bypasses the blank mask: it is a deliberate request,
    // not the stale counter level that blank exists to hide.
`ifdef TRDB_FORCE_RESYNC_EN
    assign force_trig = force_resync_i & trace_enabled_i;
`else
    assign force_trig = 1'b0;
`endif

    assign trigger = (trace_enabled_i & resync_max_i & ~blank_q) | force_trig;

    // Next-state, wait counter, completed-resync count and blank flag.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        count_d = count_q;
        blank_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_WAIT_SLOT;
                    wait_d  = '0;
                end
            end
            ST_WAIT_SLOT: begin
                if (!trace_enabled_i) begin
                    state_d = ST_IDLE;
                end else if (!packet_busy_i || (wait_q == WAIT_LAST)) begin
                    state_d = ST_REQ;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_REQ: begin
                // An ack takes priority over a disable seen in the same cycle.
                if (sync_ack_i) begin
                    state_d = ST_CLEAR;
                end else if (!trace_enabled_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
                // The counter's resync_max only drops one cycle after our
                // pulse, so ignore it for the first IDLE cycle.
                blank_d = 1'b1;
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            count_q <= '0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            blank_q <= blank_d;
        end
    end

    assign sync_req_o       = (state_q == ST_REQ);
    assign resync_rst_o     = (state_q == ST_CLEAR);
    assign resync_pending_o = (state_q == ST_WAIT_SLOT) || (state_q == ST_REQ);
    assign resync_count_o   = count_q;

endmodule
